iq_byte_demux: RTL
==================

# iq_byte_demux

Front-end sample assembler for the FM receive chain. It consumes the raw interleaved byte stream from the 8-bit input FIFO, assembles one 16-bit signed little-endian I sample and one Q sample per 4 bytes, and sign-extends and quantizes each to the 32-bit fixed-point format. It writes each I/Q pair into the I and Q sample FIFOs that the complex channel FIR drains. It is the writer end of the FIR's I/Q FIFO interface.

## Interface

Parameters:
- QUANT_BITS, 10, left-shift applied after sign extension; matches the FIR's fixed-point scale.
- SAMPLE_W, 16, width of each raw I or Q sample in the byte stream; fixed at 16 (2 bytes).

Ports (reset is asynchronous, active-high, on `reset`; clock is `clock`):
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_dout  in  8  byte at the head of the input FIFO (first-word-fall-through).
- in_empty  in  1  input FIFO empty.
- in_rd_en  out  1  pop the input FIFO this cycle.
- i_out  out  32  quantized I sample.
- q_out  out  32  quantized Q sample.
- i_wr_en  out  1  push i_out this cycle.
- q_wr_en  out  1  push q_out this cycle.
- i_full  in  1  I FIFO full.
- q_full  in  1  Q FIFO full.
- sample_count  out  32  number of I/Q pairs written since reset; wraps modulo 2^32.

## Operation

- Byte order per sample is I[7:0], I[15:8], Q[7:0], Q[15:8].
- A 2-bit byte counter (0..3) selects the byte slot.
- States:
  - READ: when in_empty=0, assert in_rd_en and latch in_dout into slot[byte_cnt], then increment byte_cnt. On byte_cnt==3 with a byte accepted, go to WRITE and wrap byte_cnt to 0. With in_empty=1, stay in READ with no pop.
  - WRITE: when i_full=0 AND q_full=0, assert i_wr_en and q_wr_en together for exactly one cycle, increment sample_count, and return to READ. Otherwise hold and assert nothing.
- Arithmetic: i_out = signed'({slot1,slot0}) sign-extended to 32 bits, then <<< QUANT_BITS. q_out uses the same rule on {slot3,slot2}. Bits shifted out are discarded. No saturation is needed, since 16+10 bits fit in 32.
- i_out and q_out are registered. They are computed on entry to WRITE, held stable throughout WRITE, and remain unchanged until the next WRITE entry.
- I and Q are never written separately. The pair stays atomic, so the FIR's I and Q FIFOs stay aligned.
- in_rd_en is deasserted in WRITE; no reads overlap a pending write.

## Timing

- Reset values: state=READ, byte_cnt=0, slots=0, i_out=q_out=0, sample_count=0.
- While reset is asserted, in_rd_en, i_wr_en and q_wr_en are 0 regardless of in_empty or state.
- in_rd_en is combinational: (state==READ) && !in_empty && !reset.
- i_wr_en and q_wr_en are combinational: (state==WRITE) && !i_full && !q_full && !reset.
- Throughput is at best 5 cycles per pair: 4 read cycles plus 1 write cycle.
- Latency: the write strobe occurs no earlier than the cycle after the 4th byte pop.
- Empty gaps between bytes only stall; partially assembled bytes are retained.
- If either output FIFO is full, the block waits in WRITE indefinitely with the data held. A full flag that falls and rises on alternate cycles produces exactly one write.
- sample_count updates on the clock edge of the write, visible the next cycle. It rolls over from 0xFFFFFFFF to 0.
- Reset mid-sample discards all partial bytes. The first 4 bytes after reset release form a new sample.

## Structure

- Shared package `fm_radio_pkg` holds:
  - the QUANT_BITS default constant (shared with the FIR),
  - `iq_state_t` {READ, WRITE},
  - the function `quantize16(logic signed [15:0]) -> logic signed [31:0]`.
- No sub-module is needed. The 8-bit input FIFO and the two 32-bit output FIFOs are the team's `fifo` instances, placed at top level. The testbench instantiates the same FIFOs around the block.

## Test plan

- Bytes 34 12 78 56 with no backpressure:
  - i_out=0x0048D000, q_out=0x0159E000;
  - one write pulse 1 cycle after the 4th pop;
  - sample_count=1.
- Bytes FF FF 00 80: i_out=0xFFFFFC00 (-1<<10), q_out=0xFE000000 (-32768<<10).
- Sample 01 00 02 00 with q_full held 1 for 10 cycles in WRITE:
  - no wr_en and no in_rd_en during the stall;
  - exactly one paired write (0x00000400, 0x00000800) on release.
- in_empty toggling every other cycle across 3 samples (12 bytes of known values):
  - 3 writes with correct values;
  - no duplicated or skipped bytes.
- Reset asserted after 2 bytes of a sample, then bytes 10 00 20 00:
  - outputs are 0 during reset;
  - the next write is i_out=0x00004000, q_out=0x00008000, with sample_count=1.
- Force sample_count to 0xFFFFFFFF, then write one sample: sample_count=0.

Source files
------------

// File: rtl/fm_radio_pkg.sv
// Shared FM receive-chain definitions: fixed-point scale, sample-assembler state, quantizer.
package fm_radio_pkg;

  localparam int unsigned QUANT_BITS_DEFAULT = 10;
  localparam int unsigned SAMPLE_W_DEFAULT   = 16;
  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned FIX_W              = 32;

  typedef enum logic [0:0] {
    READ  = 1'b0,
    WRITE = 1'b1
  } iq_state_t;

  // Sign-extend a raw 16-bit sample to 32 bits and scale by the shared fixed-point shift.
  function automatic logic signed [31:0] quantize16(input logic signed [15:0] s);
    logic signed [31:0] ext;
    ext = {{16{s[15]}}, s};
    return ext <<< QUANT_BITS_DEFAULT;
  endfunction

endpackage

// File: rtl/iq_byte_demux_if.sv
// Byte-FIFO read port plus paired I/Q FIFO write port of the sample assembler.
interface iq_byte_demux_if;
  import fm_radio_pkg::*;

  logic [BYTE_W-1:0] in_dout;
  logic              in_empty;
  logic              in_rd_en;
  logic [FIX_W-1:0]  i_out;
  logic [FIX_W-1:0]  q_out;
  logic              i_wr_en;
  logic              q_wr_en;
  logic              i_full;
  logic              q_full;
  logic [FIX_W-1:0]  sample_count;

  // Assembler side.
  modport master (
    input  in_dout, in_empty, i_full, q_full,
    output in_rd_en, i_out, q_out, i_wr_en, q_wr_en, sample_count
  );

  // FIFO / environment side.
  modport slave (
    output in_dout, in_empty, i_full, q_full,
    input  in_rd_en, i_out, q_out, i_wr_en, q_wr_en, sample_count
  );

endinterface

// File: rtl/iq_byte_demux.sv
// Assembles interleaved little-endian I/Q byte pairs into quantized 32-bit samples
// and writes them atomically into the I and Q FIFOs feeding the channel FIR.
module iq_byte_demux
  import fm_radio_pkg::*;
#(
  parameter int unsigned QUANT_BITS = QUANT_BITS_DEFAULT,
  parameter int unsigned SAMPLE_W   = SAMPLE_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  iq_byte_demux_if.master bus
);

  localparam int unsigned EXT_W = FIX_W - SAMPLE_W;

  iq_state_t                state_q, state_d;
  logic [1:0]               byte_cnt_q;
  logic [2:0][BYTE_W-1:0]   slot_q;
  logic [FIX_W-1:0]         i_q, q_q;
  logic [FIX_W-1:0]         sample_count_q;
  logic                     rd, wr;
  logic [SAMPLE_W-1:0]      i_raw, q_raw;
  logic signed [FIX_W-1:0]  i_ext, q_ext;

  // The Q high byte is taken straight from the FIFO head on the fourth pop.
  assign i_raw = {slot_q[1], slot_q[0]};
  assign q_raw = {bus.in_dout, slot_q[2]};
  assign i_ext = {{EXT_W{i_raw[SAMPLE_W-1]}}, i_raw};
  assign q_ext = {{EXT_W{q_raw[SAMPLE_W-1]}}, q_raw};

  // Next state and pop/push strobes; strobes are forced low while in reset.
  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    wr      = 1'b0;
    case (state_q)
      READ: begin
        if (!bus.in_empty) begin
          rd = 1'b1;
          if (byte_cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        if (!bus.i_full && !bus.q_full) begin
          wr      = 1'b1;
          state_d = READ;
        end
      end
      default: state_d = READ;
    endcase
    if (reset) begin
      rd = 1'b0;
      wr = 1'b0;
    end
  end

  // State, byte slots, quantized outputs and pair counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= READ;
      byte_cnt_q     <= 2'd0;
      slot_q         <= '0;
      i_q            <= '0;
      q_q            <= '0;
      sample_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0: slot_q[0] <= bus.in_dout;
          2'd1: slot_q[1] <= bus.in_dout;
          2'd2: slot_q[2] <= bus.in_dout;
          default: begin
            i_q <= FIX_W'(i_ext <<< QUANT_BITS);
            q_q <= FIX_W'(q_ext <<< QUANT_BITS);
          end
        endcase
      end
      if (wr) sample_count_q <= sample_count_q + FIX_W'(1);
    end
  end

  assign bus.in_rd_en     = rd;
  assign bus.i_wr_en      = wr;
  assign bus.q_wr_en      = wr;
  assign bus.i_out        = i_q;
  assign bus.q_out        = q_q;
  assign bus.sample_count = sample_count_q;

endmodule
